// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 set-2 key decoder.
// Contents: scan-code constants, the decoder FSM state encoding, the bit
// positions of the packed key event, and the scan-code to ASCII table.
package ps2_pkg;

    localparam logic [7:0] SC_BREAK     = 8'hF0;
    localparam logic [7:0] SC_EXT       = 8'hE0;
    localparam logic [7:0] SC_PAUSE     = 8'hE1;
    localparam logic [7:0] SC_LSHIFT    = 8'h12;
    localparam logic [7:0] SC_RSHIFT    = 8'h59;
    localparam logic [7:0] SC_CAPS      = 8'h58;
    localparam logic [7:0] SC_CTRL      = 8'h14;
    localparam logic [7:0] SC_ALT       = 8'h11;
    // Code reported for the pause key once its E1 sequence completes.
    localparam logic [7:0] SC_PAUSE_KEY = 8'h77;

    localparam int EVT_W         = 22;
    localparam int EVT_CODE_LSB  = 0;
    localparam int EVT_ASCII_LSB = 8;
    localparam int EVT_EXT       = 16;
    localparam int EVT_BRK       = 17;
    localparam int EVT_SHIFT     = 18;
    localparam int EVT_CTRL      = 19;
    localparam int EVT_ALT       = 20;
    localparam int EVT_CAPS      = 21;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_EXT     = 3'd1,
        ST_BRK     = 3'd2,
        ST_EXT_BRK = 3'd3,
        ST_PAUSE   = 3'd4
    } ps2_state_t;

    // Non-extended set-2 code to ASCII; 8'h00 for keys with no character.
    function automatic logic [7:0] ps2_to_ascii(input logic [7:0] sc, input logic shift);
        logic [7:0] a;
        a = 8'h00;
        case (sc)
            8'h1C: a = 8'h61; 8'h32: a = 8'h62; 8'h21: a = 8'h63; 8'h23: a = 8'h64;
            8'h24: a = 8'h65; 8'h2B: a = 8'h66; 8'h34: a = 8'h67; 8'h33: a = 8'h68;
            8'h43: a = 8'h69; 8'h3B: a = 8'h6A; 8'h42: a = 8'h6B; 8'h4B: a = 8'h6C;
            8'h3A: a = 8'h6D; 8'h31: a = 8'h6E; 8'h44: a = 8'h6F; 8'h4D: a = 8'h70;
            8'h15: a = 8'h71; 8'h2D: a = 8'h72; 8'h1B: a = 8'h73; 8'h2C: a = 8'h74;
            8'h3C: a = 8'h75; 8'h2A: a = 8'h76; 8'h1D: a = 8'h77; 8'h22: a = 8'h78;
            8'h35: a = 8'h79; 8'h1A: a = 8'h7A;
            8'h16: a = shift ? 8'h21 : 8'h31;
            8'h1E: a = shift ? 8'h40 : 8'h32;
            8'h26: a = shift ? 8'h23 : 8'h33;
            8'h25: a = shift ? 8'h24 : 8'h34;
            8'h2E: a = shift ? 8'h25 : 8'h35;
            8'h36: a = shift ? 8'h5E : 8'h36;
            8'h3D: a = shift ? 8'h26 : 8'h37;
            8'h3E: a = shift ? 8'h2A : 8'h38;
            8'h46: a = shift ? 8'h28 : 8'h39;
            8'h45: a = shift ? 8'h29 : 8'h30;
            8'h29: a = 8'h20;
            8'h5A: a = 8'h0D;
            8'h66: a = 8'h08;
            8'h0D: a = 8'h09;
            8'h76: a = 8'h1B;
            default: a = 8'h00;
        endcase
        if (shift && a >= 8'h61 && a <= 8'h7A) begin
            a = a - 8'h20;
        end
        return a;
    endfunction

endpackage

// File: rtl/ps2_key_decoder_fifo.sv
// key_evt_fifo: first-word-fall-through FIFO for decoded key events.
// Ports: clk, rst_n (async active-low), wr/w_data (push, dropped when full),
//        rd (pop, ignored when empty), r_data (head word), empty, full.
module key_evt_fifo #(
    parameter int D_WIDTH = 22,
    parameter int A_WIDTH = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr,
    input  logic               rd,
    input  logic [D_WIDTH-1:0] w_data,
    output logic [D_WIDTH-1:0] r_data,
    output logic               empty,
    output logic               full
);

    localparam int DEPTH = 2 ** A_WIDTH;

    logic [D_WIDTH-1:0] mem [DEPTH];
    // Extra MSB distinguishes full from empty when the address bits match.
    logic [A_WIDTH:0]   wr_ptr;
    logic [A_WIDTH:0]   rd_ptr;
    logic               do_wr;
    logic               do_rd;

    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[A_WIDTH] != rd_ptr[A_WIDTH]) &&
                    (wr_ptr[A_WIDTH-1:0] == rd_ptr[A_WIDTH-1:0]);
    assign do_wr  = wr && !full;
    assign do_rd  = rd && !empty;
    assign r_data = mem[rd_ptr[A_WIDTH-1:0]];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr[A_WIDTH-1:0]] <= w_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: set-2 scan-code decoder with modifier tracking, repeat
// filter and an event FIFO.
// Ports: clk, rst_n (async active-low); code/code_vld/code_err from the byte
//        receiver; rd pops evt (head event, valid while !empty); empty, full;
//        ovf (sticky, cleared by ovf_clr); caps_led.
//
// state      | meaning
// ST_IDLE    | waiting for a prefix or a plain make code
// ST_EXT     | E0 seen
// ST_BRK     | F0 seen
// ST_EXT_BRK | E0 F0 seen
// ST_PAUSE   | E1 seen, swallowing the rest of the pause sequence
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int A_WIDTH     = 5,
    parameter bit EMIT_BREAK  = 1'b0,
    parameter bit REPEAT_EN   = 1'b1,
    parameter int TIMEOUT_CYC = 1200000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       code,
    input  logic             code_vld,
    input  logic             code_err,
    input  logic             rd,
    output logic [EVT_W-1:0] evt,
    output logic             empty,
    output logic             full,
    output logic             ovf,
    input  logic             ovf_clr,
    output logic             caps_led
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    ps2_state_t       state, state_n;
    logic [2:0]       skip_cnt, skip_cnt_n;
    logic [TW-1:0]    tmo_cnt, tmo_cnt_n;

    logic             key_evt, key_ext, key_brk;
    logic [7:0]       key_code;
    logic [8:0]       key_id;
    logic             is_repeat;

    logic             lshift, rshift, ctrl, alt, caps;
    logic             lshift_n, rshift_n, ctrl_n, alt_n, caps_n, shift_n;
    logic [8:0]       held_key;
    logic             held_vld;

    logic             push_n, push_q;
    logic [EVT_W-1:0] evt_n, evt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            skip_cnt <= '0;
            tmo_cnt  <= '0;
        end else begin
            state    <= state_n;
            skip_cnt <= skip_cnt_n;
            tmo_cnt  <= tmo_cnt_n;
        end
    end

    always_comb begin
        state_n    = state;
        skip_cnt_n = skip_cnt;
        tmo_cnt_n  = tmo_cnt;
        if (code_err) begin
            state_n   = ST_IDLE;
            tmo_cnt_n = '0;
        end else if (code_vld) begin
            tmo_cnt_n = '0;
            case (state)
                ST_IDLE: begin
                    if (code == SC_EXT) begin
                        state_n = ST_EXT;
                    end else if (code == SC_BREAK) begin
                        state_n = ST_BRK;
                    end else if (code == SC_PAUSE) begin
                        state_n    = ST_PAUSE;
                        skip_cnt_n = 3'd7;
                    end
                end
                ST_EXT:  state_n = (code == SC_BREAK) ? ST_EXT_BRK : ST_IDLE;
                ST_PAUSE: begin
                    skip_cnt_n = skip_cnt - 3'd1;
                    if (skip_cnt == 3'd1) state_n = ST_IDLE;
                end
                default: state_n = ST_IDLE;
            endcase
        end else if (state != ST_IDLE) begin
            if (tmo_cnt == TMO_LAST) begin
                state_n   = ST_IDLE;
                tmo_cnt_n = '0;
            end else begin
                tmo_cnt_n = tmo_cnt + TW'(1);
            end
        end
    end

    always_comb begin
        key_evt  = 1'b0;
        key_ext  = 1'b0;
        key_brk  = 1'b0;
        key_code = code;
        if (code_vld && !code_err) begin
            case (state)
                ST_IDLE:    key_evt = (code != SC_EXT) && (code != SC_BREAK) && (code != SC_PAUSE);
                ST_EXT: begin
                    key_evt = (code != SC_BREAK);
                    key_ext = 1'b1;
                end
                ST_BRK: begin
                    key_evt = 1'b1;
                    key_brk = 1'b1;
                end
                ST_EXT_BRK: begin
                    key_evt = 1'b1;
                    key_ext = 1'b1;
                    key_brk = 1'b1;
                end
                ST_PAUSE: begin
                    key_evt  = (skip_cnt == 3'd1);
                    key_ext  = 1'b1;
                    key_code = SC_PAUSE_KEY;
                end
                default: ;
            endcase
        end
    end

    // Modifier next-state and event assembly; flags reflect this key applied.
    always_comb begin
        key_id    = {key_ext, key_code};
        is_repeat = !key_brk && held_vld && (held_key == key_id);
        lshift_n  = lshift;
        rshift_n  = rshift;
        ctrl_n    = ctrl;
        alt_n     = alt;
        caps_n    = caps;
        if (key_evt) begin
            if (!key_ext && key_code == SC_LSHIFT) lshift_n = !key_brk;
            if (!key_ext && key_code == SC_RSHIFT) rshift_n = !key_brk;
            if (key_code == SC_CTRL)               ctrl_n   = !key_brk;
            if (key_code == SC_ALT)                alt_n    = !key_brk;
            if (!key_ext && key_code == SC_CAPS && !key_brk && !is_repeat) caps_n = !caps;
        end
        shift_n = lshift_n | rshift_n;
        push_n  = key_evt && (key_brk ? EMIT_BREAK : (REPEAT_EN || !is_repeat));

        evt_n                                = '0;
        evt_n[EVT_CODE_LSB +: 8]             = key_code;
        evt_n[EVT_ASCII_LSB +: 8]            = key_ext ? 8'h00 : ps2_to_ascii(key_code, shift_n ^ caps_n);
        evt_n[EVT_EXT]                       = key_ext;
        evt_n[EVT_BRK]                       = key_brk;
        evt_n[EVT_SHIFT]                     = shift_n;
        evt_n[EVT_CTRL]                      = ctrl_n;
        evt_n[EVT_ALT]                       = alt_n;
        evt_n[EVT_CAPS]                      = caps_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lshift   <= 1'b0;
            rshift   <= 1'b0;
            ctrl     <= 1'b0;
            alt      <= 1'b0;
            caps     <= 1'b0;
            held_key <= '0;
            held_vld <= 1'b0;
            push_q   <= 1'b0;
            evt_q    <= '0;
            ovf      <= 1'b0;
        end else begin
            lshift <= lshift_n;
            rshift <= rshift_n;
            ctrl   <= ctrl_n;
            alt    <= alt_n;
            caps   <= caps_n;
            push_q <= push_n;
            evt_q  <= evt_n;
            if (key_evt) begin
                if (!key_brk) begin
                    held_key <= key_id;
                    held_vld <= 1'b1;
                end else if (held_vld && held_key == key_id) begin
                    held_vld <= 1'b0;
                end
            end
            // A push into a full FIFO is lost; set beats a coincident clear.
            if (push_q && full) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
        end
    end

    assign caps_led = caps;

    key_evt_fifo #(
        .D_WIDTH (EVT_W),
        .A_WIDTH (A_WIDTH)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr     (push_q),
        .rd     (rd),
        .w_data (evt_q),
        .r_data (evt),
        .empty  (empty),
        .full   (full)
    );

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder. Two instances share the byte stream:
//   dut_a: A_WIDTH=2, EMIT_BREAK=1, REPEAT_EN=0
//   dut_b: A_WIDTH=5, EMIT_BREAK=0, REPEAT_EN=1
// Expected events are queued per instance as bytes are sent and checked on pop.
module tb_ps2_key_decoder;

    localparam int TMO = 40;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  code = 8'h00;
    logic        code_vld = 1'b0;
    logic        code_err = 1'b0;
    logic        rd_a = 1'b0;
    logic        rd_b = 1'b0;
    logic        ovf_clr = 1'b0;
    logic [21:0] evt_a, evt_b;
    logic        empty_a, empty_b, full_a, full_b, ovf_a, ovf_b, caps_a, caps_b;

    logic [21:0] qa[$];
    logic [21:0] qb[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    ps2_key_decoder #(.A_WIDTH(2), .EMIT_BREAK(1'b1), .REPEAT_EN(1'b0), .TIMEOUT_CYC(TMO)) dut_a (
        .clk(clk), .rst_n(rst_n), .code(code), .code_vld(code_vld), .code_err(code_err),
        .rd(rd_a), .evt(evt_a), .empty(empty_a), .full(full_a), .ovf(ovf_a),
        .ovf_clr(ovf_clr), .caps_led(caps_a));

    ps2_key_decoder #(.A_WIDTH(5), .EMIT_BREAK(1'b0), .REPEAT_EN(1'b1), .TIMEOUT_CYC(TMO)) dut_b (
        .clk(clk), .rst_n(rst_n), .code(code), .code_vld(code_vld), .code_err(code_err),
        .rd(rd_b), .evt(evt_b), .empty(empty_b), .full(full_b), .ovf(ovf_b),
        .ovf_clr(ovf_clr), .caps_led(caps_b));

    // {caps, alt, ctrl, shift, brk, ext, ascii, code}
    function automatic logic [21:0] ev(input logic [7:0] sc, input logic [7:0] asc,
                                       input logic ext, input logic brk,
                                       input logic sh, input logic cp);
        return {cp, 1'b0, 1'b0, sh, brk, ext, asc, sc};
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        code     = b;
        code_vld = 1'b1;
        @(negedge clk);
        code_vld = 1'b0;
    endtask

    task automatic drain(input bit sel, input string tag);
        logic [21:0] exp;
        int          waitc;
        idle(3);
        while ((sel ? qb.size() : qa.size()) > 0) begin
            exp   = sel ? qb.pop_front() : qa.pop_front();
            waitc = 0;
            while ((sel ? empty_b : empty_a) && waitc < 20) begin
                @(negedge clk);
                waitc++;
            end
            n_cmp++;
            if (sel ? empty_b : empty_a) begin
                n_bad++;
                $display("FAIL %s_%s_missing: empty=1, expected evt %h", tag, sel ? "b" : "a", exp);
            end else if ((sel ? evt_b : evt_a) !== exp) begin
                n_bad++;
                $display("FAIL %s_%s_evt: got %h expected %h", tag, sel ? "b" : "a",
                         sel ? evt_b : evt_a, exp);
            end
            if (sel) rd_b = 1'b1; else rd_a = 1'b1;
            @(negedge clk);
            rd_a = 1'b0;
            rd_b = 1'b0;
        end
        idle(2);
        n_cmp++;
        if ((sel ? empty_b : empty_a) !== 1'b1) begin
            n_bad++;
            $display("FAIL %s_%s_extra: empty=%b expected 1", tag, sel ? "b" : "a",
                     sel ? empty_b : empty_a);
        end
    endtask

    task automatic test_reset();
        idle(2);
        n_cmp++;
        if ({empty_a, full_a, ovf_a, caps_a} !== 4'b1000) begin
            n_bad++;
            $display("FAIL reset_flags_a: got %b expected 1000", {empty_a, full_a, ovf_a, caps_a});
        end
        n_cmp++;
        if ({empty_b, full_b, ovf_b, caps_b} !== 4'b1000) begin
            n_bad++;
            $display("FAIL reset_flags_b: got %b expected 1000", {empty_b, full_b, ovf_b, caps_b});
        end
        @(negedge clk) rst_n = 1'b1;
        send(8'hE0);
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        n_cmp++;
        if (empty_a !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_mid_empty: got %b expected 1", empty_a);
        end
        qa.push_back(ev(8'h1C, 8'h61, 0, 0, 0, 0));
        qb.push_back(ev(8'h1C, 8'h61, 0, 0, 0, 0));
        send(8'h1C);
        n_cmp++;
        if (empty_a !== 1'b1) begin
            n_bad++;
            $display("FAIL latency_early: empty=%b expected 1", empty_a);
        end
        @(negedge clk);
        n_cmp++;
        if (empty_a !== 1'b0) begin
            n_bad++;
            $display("FAIL latency_ready: empty=%b expected 0", empty_a);
        end
        drain(0, "reset");
        drain(1, "reset");
    endtask

    task automatic test_shift();
        qa.push_back(ev(8'h12, 8'h00, 0, 0, 1, 0));
        qb.push_back(ev(8'h12, 8'h00, 0, 0, 1, 0));
        send(8'h12);
        qa.push_back(ev(8'h1C, 8'h41, 0, 0, 1, 0));
        qb.push_back(ev(8'h1C, 8'h41, 0, 0, 1, 0));
        send(8'h1C);
        qa.push_back(ev(8'h1C, 8'h41, 0, 1, 1, 0));
        send(8'hF0); send(8'h1C);
        qa.push_back(ev(8'h12, 8'h00, 0, 1, 0, 0));
        send(8'hF0); send(8'h12);
        drain(0, "shift");
        drain(1, "shift");
        n_cmp++;
        if (evt_b[18] !== 1'b0 && !empty_b) begin
            n_bad++;
            $display("FAIL shift_left_over: shift=%b expected 0", evt_b[18]);
        end
    endtask

    task automatic test_caps_repeat();
        qa.push_back(ev(8'h58, 8'h00, 0, 0, 0, 1));
        qb.push_back(ev(8'h58, 8'h00, 0, 0, 0, 1));
        send(8'h58);
        qb.push_back(ev(8'h58, 8'h00, 0, 0, 0, 1));
        send(8'h58);
        qa.push_back(ev(8'h58, 8'h00, 0, 1, 0, 1));
        send(8'hF0); send(8'h58);
        qa.push_back(ev(8'h1C, 8'h41, 0, 0, 0, 1));
        qb.push_back(ev(8'h1C, 8'h41, 0, 0, 0, 1));
        send(8'h1C);
        qb.push_back(ev(8'h1C, 8'h41, 0, 0, 0, 1));
        send(8'h1C);
        idle(2);
        n_cmp++;
        if ({caps_a, caps_b} !== 2'b11) begin
            n_bad++;
            $display("FAIL caps_on: got %b expected 11", {caps_a, caps_b});
        end
        drain(0, "caps");
        drain(1, "caps");
        qa.push_back(ev(8'h58, 8'h00, 0, 0, 0, 0));
        qb.push_back(ev(8'h58, 8'h00, 0, 0, 0, 0));
        send(8'h58);
        qa.push_back(ev(8'h58, 8'h00, 0, 1, 0, 0));
        send(8'hF0); send(8'h58);
        idle(2);
        n_cmp++;
        if ({caps_a, caps_b} !== 2'b00) begin
            n_bad++;
            $display("FAIL caps_off: got %b expected 00", {caps_a, caps_b});
        end
        drain(0, "caps_off");
        drain(1, "caps_off");
    endtask

    task automatic test_ext_pause();
        logic [7:0] pause_seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        qa.push_back(ev(8'h75, 8'h00, 1, 0, 0, 0));
        qb.push_back(ev(8'h75, 8'h00, 1, 0, 0, 0));
        send(8'hE0); send(8'h75);
        qa.push_back(ev(8'h75, 8'h00, 1, 1, 0, 0));
        send(8'hE0); send(8'hF0); send(8'h75);
        qa.push_back(ev(8'h77, 8'h00, 1, 0, 0, 0));
        qb.push_back(ev(8'h77, 8'h00, 1, 0, 0, 0));
        for (int i = 0; i < 8; i++) send(pause_seq[i]);
        drain(0, "ext_pause");
        drain(1, "ext_pause");
    endtask

    task automatic test_overflow();
        logic [7:0] keys [6] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B};
        for (int i = 0; i < 4; i++) begin
            qa.push_back(ev(keys[i], 8'(8'h61 + i), 0, 0, 0, 0));
            qb.push_back(ev(keys[i], 8'(8'h61 + i), 0, 0, 0, 0));
            send(keys[i]);
        end
        idle(2);
        n_cmp++;
        if ({full_a, ovf_a, full_b} !== 3'b100) begin
            n_bad++;
            $display("FAIL ovf_full4: full_a,ovf_a,full_b=%b expected 100", {full_a, ovf_a, full_b});
        end
        qb.push_back(ev(keys[4], 8'h65, 0, 0, 0, 0));
        send(keys[4]);
        idle(2);
        n_cmp++;
        if ({full_a, ovf_a, ovf_b} !== 3'b110) begin
            n_bad++;
            $display("FAIL ovf_set: full_a,ovf_a,ovf_b=%b expected 110", {full_a, ovf_a, ovf_b});
        end
        // clear held across the cycle a dropped push lands: set must win
        qb.push_back(ev(keys[5], 8'h66, 0, 0, 0, 0));
        @(negedge clk);
        code = keys[5]; code_vld = 1'b1; ovf_clr = 1'b1;
        @(negedge clk);
        code_vld = 1'b0;
        @(negedge clk);
        ovf_clr = 1'b0;
        n_cmp++;
        if (ovf_a !== 1'b1) begin
            n_bad++;
            $display("FAIL ovf_set_wins: ovf=%b expected 1", ovf_a);
        end
        drain(0, "ovf");
        drain(1, "ovf");
        n_cmp++;
        if (ovf_a !== 1'b1) begin
            n_bad++;
            $display("FAIL ovf_sticky: ovf=%b expected 1", ovf_a);
        end
        @(negedge clk) ovf_clr = 1'b1;
        @(negedge clk) ovf_clr = 1'b0;
        n_cmp++;
        if (ovf_a !== 1'b0) begin
            n_bad++;
            $display("FAIL ovf_clear: ovf=%b expected 0", ovf_a);
        end
    endtask

    task automatic test_timeout_err();
        qa.push_back(ev(8'h1C, 8'h61, 0, 0, 0, 0));
        qb.push_back(ev(8'h1C, 8'h61, 0, 0, 0, 0));
        send(8'hF0);
        idle(TMO);
        send(8'h1C);
        qa.push_back(ev(8'h1C, 8'h61, 0, 1, 0, 0));
        send(8'hF0);
        idle(10);
        send(8'h1C);
        drain(0, "timeout");
        drain(1, "timeout");
        qa.push_back(ev(8'h75, 8'h00, 0, 0, 0, 0));
        qb.push_back(ev(8'h75, 8'h00, 0, 0, 0, 0));
        send(8'hE0);
        @(negedge clk) code_err = 1'b1;
        @(negedge clk) code_err = 1'b0;
        send(8'h75);
        qa.push_back(ev(8'h1C, 8'h61, 0, 0, 0, 0));
        qb.push_back(ev(8'h1C, 8'h61, 0, 0, 0, 0));
        @(negedge clk);
        code = 8'hE0; code_vld = 1'b1; code_err = 1'b1;
        @(negedge clk);
        code_vld = 1'b0; code_err = 1'b0;
        send(8'h1C);
        drain(0, "err");
        drain(1, "err");
    endtask

    initial begin
        test_reset();
        test_shift();
        test_caps_repeat();
        test_ext_pause();
        test_overflow();
        test_timeout_err();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, compared %0d", n_cmp);
        $fatal(1);
    end

endmodule

// File: doc/ps2_key_decoder.md
Name: ps2_key_decoder

Overview:
- Parametrised keyboard scan-code decoder; sits between the PS/2 byte receiver (framed bytes out) and the consumer (UART/console logic).
- Handles set-2 prefixes E0 (extended), F0 (break) and E1 (pause), and tracks shift, ctrl, alt and caps-lock state.
- Optionally suppresses typematic repeats and optionally emits break events.
- Pushes packed key events into an internal first-word-fall-through FIFO with a read handshake and overflow reporting.

Parameters:
- A_WIDTH, 5, FIFO address width; depth = 2**A_WIDTH events.
- EMIT_BREAK, 0, 1 = release events are queued; 0 = only make events are queued.
- REPEAT_EN, 1, 1 = typematic repeats are queued; 0 = a repeated make of the held key is dropped.
- TIMEOUT_CYC, 1200000, idle clk cycles after a prefix byte before the decoder abandons the sequence (100 ms at 12 MHz).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- code  in  8  scan-code byte from the PS/2 receiver
- code_vld  in  1  one-cycle strobe; code is valid
- code_err  in  1  one-cycle strobe; receiver frame/parity error
- rd  in  1  pop the head event; ignored when empty
- evt  out  22  head event, valid while !empty
- empty  out  1  FIFO empty
- full  out  1  FIFO full
- ovf  out  1  sticky overflow flag
- ovf_clr  in  1  clears ovf
- caps_led  out  1  current caps-lock state

Behaviour:
- Event word layout:
  - [7:0] scan code, with prefixes stripped.
  - [15:8] ASCII from the ps2_to_ascii table, driven with shift_eff = shift ^ caps; 8'h00 when ext=1.
  - [16] ext.
  - [17] brk.
  - [18] shift.
  - [19] ctrl.
  - [20] alt.
  - [21] caps.
- Modifier flags carry the state after the current code has been applied.
- Reset (rst_n=0, async):
  - State IDLE; all modifier state 0; caps_led=0; ovf=0; FIFO emptied; empty=1; full=0; timeout counter 0; held-key register invalid.
- FSM, one transition per code_vld:
  - IDLE: E0 goes to EXT; F0 goes to BRK; E1 goes to PAUSE with skip counter 7; any other byte is a make, processed and stays IDLE.
  - EXT: F0 goes to EXT_BRK; any other byte is an extended make, then IDLE.
  - BRK: any byte is a break, then IDLE.
  - EXT_BRK: any byte is an extended break, then IDLE.
  - PAUSE: decrements the skip counter on each code_vld; at 0, emits the make event for code 8'h77 with ext=1 and returns to IDLE.
- Timeout and error recovery:
  - In any state except IDLE, the timeout counter increments each cycle without code_vld and resets on code_vld.
  - When the counter reaches TIMEOUT_CYC-1, the FSM goes to IDLE and no event is produced.
  - code_err in any state forces IDLE and drops the partial sequence; modifier state is unchanged.
  - If code_err and code_vld arrive in the same cycle, code_err wins.
- Modifiers:
  - Shift = left shift (12) OR right shift (59); each is tracked separately.
  - Ctrl = 14, with or without E0.
  - Alt = 11, with or without E0.
  - Make sets the modifier; break clears it.
  - Caps lock (58) toggles caps only on a non-repeat make; its break does nothing.
  - Modifier and caps codes still produce events, subject to EMIT_BREAK and REPEAT_EN.
- Repeat filter:
  - The held-key register stores {ext, code} of the last make.
  - A make equal to the held key is a repeat.
  - A break matching the held key invalidates the register.
  - When REPEAT_EN=0, repeats are not pushed.
- Break events are pushed only when EMIT_BREAK=1.
- Latency: code_vld on the final byte at cycle N gives a registered push at N+1; empty falls and evt is valid at N+2.
- FIFO:
  - First-word-fall-through; rd while !empty pops and the next word appears on the following cycle.
  - A push while full is dropped and sets ovf, even if rd is asserted in the same cycle.
  - rd and a push together while not full: both take effect and the occupancy is unchanged.
  - ovf_clr clears ovf; if ovf_clr coincides with a new overflow, set wins.
- Pointers wrap modulo 2**A_WIDTH; full and empty are derived from pointers carrying an extra MSB.

Decomposition:
- Shared package ps2_pkg holds:
  - Scan-code constants: BREAK=F0, EXT=E0, PAUSE=E1, LSHIFT=12, RSHIFT=59, CAPS=58, CTRL=14, ALT=11.
  - FSM state encoding.
  - Event-field bit indices.
- The ASCII lookup reuses ps2_to_ascii.
- One sub-module: key_evt_fifo, a parametrised first-word-fall-through FIFO (D_WIDTH=22, A_WIDTH).
  - It exposes wr, rd, w_data, r_data, empty and full.
  - It contains no overflow logic; ovf lives in the top level.

Test Plan:
1. Reset mid-sequence: drive E0, assert rst_n=0 for 1 cycle, then send 1C -> one event, evt[7:0]=1C, ext=0, ASCII 'a' (61); empty=1 before it.
2. Shifted letter: 12, 1C, F0 1C, F0 12 with EMIT_BREAK=0 -> events 12 (shift=1), then 1C with ASCII 'A' (41); empty after 2 pops; shift=0 at the end.
3. Caps and repeat: with REPEAT_EN=0, send 58, 58, F0 58, then 1C, 1C -> caps_led=1 (the second 58 does not toggle); exactly one 1C event with ASCII 41.
4. Extended keys and pause: E0 75, then E0 F0 75 with EMIT_BREAK=1, then the 8-byte E1 sequence -> events {ext=1, brk=0, 75}, {ext=1, brk=1, 75}, {ext=1, 77}.
5. Overflow: A_WIDTH=2, push 5 makes with no reads -> full=1 after 4; ovf=1; the fifth is dropped; pop 4 gives the first four in order; ovf_clr clears ovf.
6. Timeout and error: send F0, then stall TIMEOUT_CYC cycles, then send 1C -> a make event (not a break). Separately, send E0 with code_err, then 75 -> a make with ext=0.
